// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu control unit: opcodes, mux select codes,
// FSM state encoding and the decoded-instruction flag bundle.
package cpu_ctrl_pkg;

  localparam logic [3:0] OC_MOV  = 4'h0;
  localparam logic [3:0] OC_ADD  = 4'h1;
  localparam logic [3:0] OC_SUB  = 4'h2;
  localparam logic [3:0] OC_MUL  = 4'h3;
  localparam logic [3:0] OC_DIV  = 4'h4;
  localparam logic [3:0] OC_IN   = 4'h7;
  localparam logic [3:0] OC_OUT  = 4'h8;
  localparam logic [3:0] OC_STOP = 4'hF;

  localparam logic [2:0] ASEL_PC = 3'd0;
  localparam logic [2:0] ASEL_A1 = 3'd1;
  localparam logic [2:0] ASEL_A2 = 3'd2;
  localparam logic [2:0] ASEL_A3 = 3'd3;
  localparam logic [2:0] ASEL_EA = 3'd4;

  localparam logic [1:0] ACC_MEM = 2'd0;
  localparam logic [1:0] ACC_ALU = 2'd1;
  localparam logic [1:0] ACC_IN  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_MUL = 2'd2;
  localparam logic [1:0] ALU_DIV = 2'd3;

  localparam logic [4:0] S_FETCH      = 5'd0;
  localparam logic [4:0] S_FETCH_W    = 5'd1;
  localparam logic [4:0] S_DECODE     = 5'd2;
  localparam logic [4:0] S_FETCH_LO   = 5'd3;
  localparam logic [4:0] S_FETCH_LO_W = 5'd4;
  localparam logic [4:0] S_PTR1       = 5'd5;
  localparam logic [4:0] S_PTR1_W     = 5'd6;
  localparam logic [4:0] S_RD1        = 5'd7;
  localparam logic [4:0] S_RD1_W      = 5'd8;
  localparam logic [4:0] S_PTR2       = 5'd9;
  localparam logic [4:0] S_PTR2_W     = 5'd10;
  localparam logic [4:0] S_RD2        = 5'd11;
  localparam logic [4:0] S_RD2_W      = 5'd12;
  localparam logic [4:0] S_PTR3       = 5'd13;
  localparam logic [4:0] S_PTR3_W     = 5'd14;
  localparam logic [4:0] S_RD3        = 5'd15;
  localparam logic [4:0] S_RD3_W      = 5'd16;
  localparam logic [4:0] S_WR         = 5'd17;
  localparam logic [4:0] S_HALT       = 5'd18;

  typedef struct packed {
    logic is_const_mov;
    logic needs_src2;
    logic needs_src3;
    logic is_in;
    logic is_out;
    logic is_stop;
    logic is_illegal;
  } decode_t;

  // Arithmetic opcodes 1..4 map directly onto ALU codes 0..3.
  function automatic logic [1:0] alu_op_of(input logic [3:0] oc);
    logic [3:0] d;
    d = oc - 4'd1;
    return d[1:0];
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction classifier: turns the 16-bit instruction word
// into the routing flags the control FSM branches on.
module cpu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output decode_t     flags
);

  logic [3:0] oc;
  logic       arith;
  logic       unused_fields;

  assign oc            = instr[15:12];
  assign unused_fields = ^instr[11:4];
  assign arith         = (oc == OC_ADD) || (oc == OC_SUB) || (oc == OC_MUL) || (oc == OC_DIV);

  always_comb begin
    flags              = '0;
    // The constant form of MOV carries its operand in the following word.
    flags.is_const_mov = (oc == OC_MOV) && (instr[3:0] == 4'b1000);
    flags.needs_src2   = arith || ((oc == OC_MOV) && !flags.is_const_mov);
    flags.needs_src3   = arith;
    flags.is_in        = (oc == OC_IN);
    flags.is_out       = (oc == OC_OUT);
    flags.is_stop      = (oc == OC_STOP);
    flags.is_illegal   = !(arith || (oc == OC_MOV) || flags.is_in || flags.is_out || flags.is_stop);
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Control FSM for the cpu datapath: sequences fetch, decode, operand reads
// (direct or through EA) and the accumulator write-back.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ir,
  output logic                  pc_inc,
  output logic                  ir_high_ld,
  output logic                  ir_low_ld,
  output logic                  acc_ld,
  output logic [1:0]            acc_sel,
  output logic [1:0]            alu_op,
  output logic                  ea_ld,
  output logic [2:0]            addr_sel,
  output logic                  mem_we,
  output logic                  out_ld,
  output logic                  halted
);

  logic [4:0] state_reg;
  logic [4:0] state_next;
  logic [3:0] oc;
  logic       ind1;
  logic       ind2;
  logic       ind3;
  logic [4:0] dst_state;
  logic [4:0] src1_state;
  logic [4:0] src2_state;
  logic [4:0] src3_state;
  decode_t    dec;

  assign oc   = ir[15:12];
  assign ind1 = ir[11];
  assign ind2 = ir[7];
  assign ind3 = ir[3];

  generate
    if (DATA_WIDTH > 16) begin : g_wide_ir
      logic unused_high;
      assign unused_high = ^ir[DATA_WIDTH-1:16];
    end
  endgenerate

  cpu_decode u_decode (
    .instr (ir[15:0]),
    .flags (dec)
  );

  // Operand fetches go through PTRk/PTRk_W first when the field is indirect.
  assign dst_state  = ind1 ? S_PTR1 : S_WR;
  assign src1_state = ind1 ? S_PTR1 : S_RD1;
  assign src2_state = ind2 ? S_PTR2 : S_RD2;
  assign src3_state = ind3 ? S_PTR3 : S_RD3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:      state_next = S_FETCH_W;
      S_FETCH_W:    state_next = S_DECODE;
      S_DECODE: begin
        if (dec.is_stop)           state_next = S_HALT;
        else if (dec.is_in)        state_next = dst_state;
        else if (dec.is_out)       state_next = src1_state;
        else if (dec.is_const_mov) state_next = S_FETCH_LO;
        else if (dec.needs_src2)   state_next = src2_state;
        else if (dec.is_illegal)   state_next = S_FETCH;
      end
      S_FETCH_LO:   state_next = S_FETCH_LO_W;
      S_FETCH_LO_W: state_next = dst_state;
      S_PTR1:       state_next = S_PTR1_W;
      // PTR1 serves both the OUT source and the write-back destination.
      S_PTR1_W:     state_next = dec.is_out ? S_RD1 : S_WR;
      S_RD1:        state_next = S_RD1_W;
      S_RD1_W:      state_next = S_FETCH;
      S_PTR2:       state_next = S_PTR2_W;
      S_PTR2_W:     state_next = S_RD2;
      S_RD2:        state_next = S_RD2_W;
      S_RD2_W:      state_next = dec.needs_src3 ? src3_state : dst_state;
      S_PTR3:       state_next = S_PTR3_W;
      S_PTR3_W:     state_next = S_RD3;
      S_RD3:        state_next = S_RD3_W;
      S_RD3_W:      state_next = dst_state;
      S_WR:         state_next = S_FETCH;
      S_HALT:       state_next = S_HALT;
      default:      state_next = S_FETCH;
    endcase
  end

  // Strobes are suppressed while rst is high so an abandoned WR never writes.
  always_comb begin
    pc_inc     = 1'b0;
    ir_high_ld = 1'b0;
    ir_low_ld  = 1'b0;
    acc_ld     = 1'b0;
    acc_sel    = ACC_MEM;
    alu_op     = ALU_ADD;
    ea_ld      = 1'b0;
    addr_sel   = ASEL_PC;
    mem_we     = 1'b0;
    out_ld     = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH_W: begin
          ir_high_ld = 1'b1;
          pc_inc     = 1'b1;
        end
        S_DECODE: begin
          if (dec.is_in) begin
            acc_ld  = 1'b1;
            acc_sel = ACC_IN;
          end
        end
        S_FETCH_LO_W: begin
          ir_low_ld = 1'b1;
          pc_inc    = 1'b1;
          acc_ld    = 1'b1;
          acc_sel   = ACC_MEM;
        end
        S_PTR1:   addr_sel = ASEL_A1;
        S_PTR2:   addr_sel = ASEL_A2;
        S_PTR3:   addr_sel = ASEL_A3;
        S_PTR1_W, S_PTR2_W, S_PTR3_W: ea_ld = 1'b1;
        S_RD1:    addr_sel = ind1 ? ASEL_EA : ASEL_A1;
        S_RD2:    addr_sel = ind2 ? ASEL_EA : ASEL_A2;
        S_RD3:    addr_sel = ind3 ? ASEL_EA : ASEL_A3;
        S_RD1_W:  out_ld = 1'b1;
        S_RD2_W: begin
          acc_ld  = 1'b1;
          acc_sel = ACC_MEM;
        end
        S_RD3_W: begin
          acc_ld  = 1'b1;
          acc_sel = ACC_ALU;
          alu_op  = alu_op_of(oc);
        end
        S_WR: begin
          mem_we   = 1'b1;
          addr_sel = ind1 ? ASEL_EA : ASEL_A1;
        end
        S_HALT:   halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
